// File: rtl/multicycle_controller_if.sv
// Bundle between the multicycle controller and the processor datapath.
// The master side is the controller: it takes opcode/flags/ack and drives strobes and selects.
interface multicycle_controller_if;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_src;
    logic        ir_write;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, state, halted, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, state, halted, retired
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle datapath sequencer: fetch/decode/exec/mem/writeback with illegal-opcode
// trap, memory-wait timeout and a retired-instruction counter.
//   state  | meaning
//   FETCH  | load IR and old PC, PC <= PC+4
//   DECODE | latch opcode, ALUOut <= branch target
//   EXEC   | ALU operation; BEQ resolves here
//   MEM    | data access, waits for mem_ready
//   WB     | register file write
//   TRAP   | halted until reset
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] retired_q;
    logic        retire;

    logic        pc_write_c, pc_src_c, ir_write_c, reg_write_c;
    logic        mem_read_c, mem_write_c, mem_to_reg_c;
    logic [1:0]  alu_src_a_c, alu_src_b_c, alu_op_c;

    logic is_ld, is_sd;
    assign is_ld = (op_q == OP_LD);
    assign is_sd = (op_q == OP_SD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            if (retire) retired_q <= retired_q + 32'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wait_d       = wait_q;
        retire       = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;

        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b10;
                op_d        = bus.opcode;
                case (bus.opcode)
                    OP_R, OP_I, OP_LD, OP_SD, OP_BEQ: state_d = S_EXEC;
                    default:                          state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                wait_d      = '0;
                alu_src_a_c = 2'b01;
                case (op_q)
                    OP_R: begin
                        alu_op_c = 2'b10;
                        state_d  = S_WB;
                    end
                    OP_I: begin
                        alu_src_b_c = 2'b01;
                        alu_op_c    = 2'b10;
                        state_d     = S_WB;
                    end
                    OP_LD, OP_SD: begin
                        alu_src_b_c = 2'b01;
                        state_d     = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op_c   = 2'b01;
                        pc_write_c = bus.zero;
                        pc_src_c   = 1'b1;
                        retire     = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                mem_read_c  = is_ld;
                mem_write_c = is_sd;
                if (bus.mem_ready) begin
                    state_d = is_ld ? S_WB : S_FETCH;
                    retire  = is_sd;
                end else begin
                    // wait_q counts MEM cycles already spent without an ack
                    wait_d = wait_q + 8'd1;
                    if (wait_q == WAIT_LAST) state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = is_ld;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Reset must kill strobes combinationally, even before state_q settles.
    assign bus.pc_write   = pc_write_c   & ~reset;
    assign bus.pc_src     = pc_src_c     & ~reset;
    assign bus.ir_write   = ir_write_c   & ~reset;
    assign bus.reg_write  = reg_write_c  & ~reset;
    assign bus.mem_read   = mem_read_c   & ~reset;
    assign bus.mem_write  = mem_write_c  & ~reset;
    assign bus.mem_to_reg = mem_to_reg_c & ~reset;
    assign bus.alu_src_a  = reset ? 2'b00 : alu_src_a_c;
    assign bus.alu_src_b  = reset ? 2'b00 : alu_src_b_c;
    assign bus.alu_op     = reset ? 2'b00 : alu_op_c;
    assign bus.state      = state_q;
    assign bus.halted     = (state_q == S_TRAP) & ~reset;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected outputs are queued with
// their stimulus and compared as the controller steps through each instruction.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;

    multicycle_controller_if bus();

    multicycle_controller #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {state, pc_write, pc_src, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
    //  alu_src_a, alu_src_b, alu_op, halted}
    function automatic logic [16:0] mk(input int st, input int pw, input int ps, input int iw,
                                       input int rw, input int mr, input int mw, input int mtr,
                                       input int a, input int b, input int op, input int h);
        return {3'(st), 1'(pw), 1'(ps), 1'(iw), 1'(rw), 1'(mr), 1'(mw), 1'(mtr),
                2'(a), 2'(b), 2'(op), 1'(h)};
    endfunction

    localparam logic [16:0] V_F   = mk(0, 1,0,1,0,0,0,0, 0,0,0, 0);
    localparam logic [16:0] V_D   = mk(1, 0,0,0,0,0,0,0, 2,2,0, 0);
    localparam logic [16:0] V_ER  = mk(2, 0,0,0,0,0,0,0, 1,0,2, 0);
    localparam logic [16:0] V_EI  = mk(2, 0,0,0,0,0,0,0, 1,1,2, 0);
    localparam logic [16:0] V_EM  = mk(2, 0,0,0,0,0,0,0, 1,1,0, 0);
    localparam logic [16:0] V_EB0 = mk(2, 0,1,0,0,0,0,0, 1,0,1, 0);
    localparam logic [16:0] V_EB1 = mk(2, 1,1,0,0,0,0,0, 1,0,1, 0);
    localparam logic [16:0] V_ML  = mk(3, 0,0,0,0,1,0,0, 0,0,0, 0);
    localparam logic [16:0] V_MS  = mk(3, 0,0,0,0,0,1,0, 0,0,0, 0);
    localparam logic [16:0] V_WR  = mk(4, 0,0,0,1,0,0,0, 0,0,0, 0);
    localparam logic [16:0] V_WL  = mk(4, 0,0,0,1,0,0,1, 0,0,0, 0);
    localparam logic [16:0] V_T   = mk(7, 0,0,0,0,0,0,0, 0,0,0, 1);
    localparam logic [16:0] V_RST = 17'd0;

    typedef struct packed {
        logic        rdy;
        logic        zro;
        logic [16:0] exp;
    } step_t;

    step_t       sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ret_model = '0;

    function automatic logic [16:0] obs();
        return {bus.state, bus.pc_write, bus.pc_src, bus.ir_write, bus.reg_write,
                bus.mem_read, bus.mem_write, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic r, input logic z, input logic [16:0] e);
        step_t s;
        s.rdy = r;
        s.zro = z;
        s.exp = e;
        sb.push_back(s);
    endtask

    // mem_ready/zero are don't-care outside MEM/BEQ-EXEC, so randomise them there
    task automatic push_x(input logic [16:0] e);
        push(1'($urandom), 1'($urandom), e);
    endtask

    // Called just after a falling edge; each step is checked mid-low-phase.
    task automatic drain(input string name, input logic [6:0] op);
        int   i;
        step_t s;
        i = 0;
        bus.opcode = op;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (i >= 2) bus.opcode = 7'($urandom);
            bus.mem_ready = s.rdy;
            bus.zero      = s.zro;
            #1;
            check($sformatf("%s c%0d", name, i), 32'(obs()), 32'(s.exp));
            @(posedge clk);
            @(negedge clk);
            i++;
        end
    endtask

    // kind: 0 R, 1 I, 2 LD, 3 SD, 4 BEQ
    task automatic run(input string name, input int kind, input logic z, input int nwait);
        logic [6:0] op;
        op = OP_R;
        push_x(V_F);
        push_x(V_D);
        case (kind)
            0: begin op = OP_R; push_x(V_ER); push_x(V_WR); end
            1: begin op = OP_I; push_x(V_EI); push_x(V_WR); end
            2: begin
                op = OP_LD;
                push_x(V_EM);
                for (int k = 0; k < nwait; k++) push(1'b0, 1'($urandom), V_ML);
                push(1'b1, 1'($urandom), V_ML);
                push_x(V_WL);
            end
            3: begin
                op = OP_SD;
                push_x(V_EM);
                for (int k = 0; k < nwait; k++) push(1'b0, 1'($urandom), V_MS);
                push(1'b1, 1'($urandom), V_MS);
            end
            default: begin
                op = OP_BEQ;
                push(1'($urandom), z, z ? V_EB1 : V_EB0);
            end
        endcase
        drain(name, op);
        ret_model = ret_model + 32'd1;
        #1;
        check({name, " retired"}, bus.retired, ret_model);
        check({name, " back in fetch"}, 32'(bus.state), 32'd0);
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        ret_model = '0;
        check({name, " outputs"}, 32'(obs()), 32'(V_RST));
        check({name, " retired"}, bus.retired, ret_model);
        @(negedge clk);
        @(negedge clk);
        check({name, " held"}, 32'(obs()), 32'(V_RST));
        reset = 1'b0;
    endtask

    initial begin
        bus.opcode    = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        do_reset("reset");

        run("r-type", 0, 1'b0, 0);
        run("i-alu", 1, 1'b0, 0);
        run("ld wait2", 2, 1'b0, 2);
        run("sd", 3, 1'b0, 0);
        run("sd wait1", 3, 1'b0, 1);
        run("beq taken", 4, 1'b1, 0);
        run("beq not taken", 4, 1'b0, 0);
        run("ld", 2, 1'b0, 0);

        // counter wrap on a completed store
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        ret_model = 32'hFFFF_FFFF;
        run("sd wrap", 3, 1'b0, 0);

        // asynchronous reset between edges while a store is waiting
        push_x(V_F);
        push_x(V_D);
        push_x(V_EM);
        push(1'b0, 1'b0, V_MS);
        drain("sd mid", OP_SD);
        bus.mem_ready = 1'b0;
        #1;
        check("mid-mem strobe", 32'(obs()), 32'(V_MS));
        #2;
        reset = 1'b1;
        #1;
        check("async reset outputs", 32'(obs()), 32'(V_RST));
        check("async reset mem_write", 32'(bus.mem_write), 32'd0);
        ret_model = '0;
        check("async reset retired", bus.retired, ret_model);
        @(negedge clk);
        reset = 1'b0;
        run("r after reset", 0, 1'b0, 0);
        run("i after reset", 1, 1'b0, 0);

        // illegal opcode traps after decode and stays there
        push_x(V_F);
        push_x(V_D);
        for (int k = 0; k < 22; k++) push_x(V_T);
        drain("illegal", OP_BAD);
        #1;
        check("illegal retired", bus.retired, ret_model);
        do_reset("reset from trap");
        run("r after trap", 0, 1'b0, 0);

        // store timeout: exactly 15 cycles of mem_write, then trap
        push_x(V_F);
        push_x(V_D);
        push_x(V_EM);
        for (int k = 0; k < 15; k++) push(1'b0, 1'($urandom), V_MS);
        for (int k = 0; k < 3; k++) push_x(V_T);
        drain("sd timeout", OP_SD);
        #1;
        check("timeout retired", bus.retired, ret_model);
        do_reset("reset from timeout");
        run("ld after timeout", 2, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
